// File: rtl/alu_pkg.sv
// Shared definitions for the alu_issue decode/issue stage: one-hot ALU control
// indices, MIPS opcode/funct encodings and the issue-bundle payload.
package alu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned CTRL_W   = 12;
    localparam int unsigned BUNDLE_W = CTRL_W + 2 * XLEN + REG_W + 2;

    localparam int unsigned ALU_ADD  = 11;
    localparam int unsigned ALU_SUB  = 10;
    localparam int unsigned ALU_SLT  = 9;
    localparam int unsigned ALU_SLTU = 8;
    localparam int unsigned ALU_AND  = 7;
    localparam int unsigned ALU_NOR  = 6;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_SLL  = 3;
    localparam int unsigned ALU_SRL  = 2;
    localparam int unsigned ALU_SRA  = 1;
    localparam int unsigned ALU_LUI  = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [CTRL_W-1:0] alu_control;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [REG_W-1:0]  dest;
        logic              wen;
        logic              illegal;
    } issue_t;

    function automatic logic [CTRL_W-1:0] onehot(input int unsigned idx);
        onehot = CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational MIPS decode into an ALU issue bundle (one-hot control, operands,
// destination, write enable, illegal flag).
module alu_dec
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]     i_inst,
    input  logic [XLEN-1:0]     i_rs_value,
    input  logic [XLEN-1:0]     i_rt_value,
    output logic [BUNDLE_W-1:0] o_bundle_c
);

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [REG_W-1:0]  w_rt;
    logic [REG_W-1:0]  w_rd;
    logic [REG_W-1:0]  w_sa;
    logic [15:0]       w_imm;
    logic [XLEN-1:0]   w_simm;
    logic [XLEN-1:0]   w_zimm;
    logic [CTRL_W-1:0] w_ctrl;
    logic [XLEN-1:0]   w_src1;
    logic [XLEN-1:0]   w_src2;
    logic [REG_W-1:0]  w_dest;
    logic              w_legal;
    logic              w_unused_rs;
    issue_t            w_bundle;

    assign w_op    = i_inst[31:26];
    assign w_rt    = i_inst[20:16];
    assign w_rd    = i_inst[15:11];
    assign w_sa    = i_inst[10:6];
    assign w_funct = i_inst[5:0];
    assign w_imm   = i_inst[15:0];
    assign w_simm  = {{16{w_imm[15]}}, w_imm};
    assign w_zimm  = {16'b0, w_imm};

    // rs index is unneeded: the register value arrives already read.
    assign w_unused_rs = ^i_inst[25:21];

    always_comb begin
        w_ctrl  = '0;
        w_src1  = i_rs_value;
        w_src2  = i_rt_value;
        w_dest  = w_rd;
        w_legal = 1'b1;
        case (w_op)
            OP_SPECIAL: begin
                case (w_funct)
                    FN_ADDU: w_ctrl = onehot(ALU_ADD);
                    FN_SUBU: w_ctrl = onehot(ALU_SUB);
                    FN_SLT:  w_ctrl = onehot(ALU_SLT);
                    FN_SLTU: w_ctrl = onehot(ALU_SLTU);
                    FN_AND:  w_ctrl = onehot(ALU_AND);
                    FN_OR:   w_ctrl = onehot(ALU_OR);
                    FN_XOR:  w_ctrl = onehot(ALU_XOR);
                    FN_NOR:  w_ctrl = onehot(ALU_NOR);
                    FN_SLL, FN_SRL, FN_SRA: begin
                        w_src1 = i_rt_value;
                        w_src2 = XLEN'(w_sa);
                        w_ctrl = (w_funct == FN_SLL) ? onehot(ALU_SLL) :
                                 (w_funct == FN_SRL) ? onehot(ALU_SRL) : onehot(ALU_SRA);
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        w_src1 = i_rt_value;
                        w_src2 = XLEN'(i_rs_value[4:0]);
                        w_ctrl = (w_funct == FN_SLLV) ? onehot(ALU_SLL) :
                                 (w_funct == FN_SRLV) ? onehot(ALU_SRL) : onehot(ALU_SRA);
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin w_ctrl = onehot(ALU_ADD);  w_src2 = w_simm; w_dest = w_rt; end
            OP_SLTI:  begin w_ctrl = onehot(ALU_SLT);  w_src2 = w_simm; w_dest = w_rt; end
            OP_SLTIU: begin w_ctrl = onehot(ALU_SLTU); w_src2 = w_simm; w_dest = w_rt; end
            OP_ANDI:  begin w_ctrl = onehot(ALU_AND);  w_src2 = w_zimm; w_dest = w_rt; end
            OP_ORI:   begin w_ctrl = onehot(ALU_OR);   w_src2 = w_zimm; w_dest = w_rt; end
            OP_XORI:  begin w_ctrl = onehot(ALU_XOR);  w_src2 = w_zimm; w_dest = w_rt; end
            OP_LUI:   begin w_ctrl = onehot(ALU_LUI);  w_src2 = w_zimm; w_dest = w_rt; end
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_bundle.alu_control = w_legal ? w_ctrl : '0;
        w_bundle.src1        = w_src1;
        w_bundle.src2        = w_src2;
        w_bundle.dest        = w_dest;
        w_bundle.wen         = w_legal && (w_dest != '0);
        w_bundle.illegal     = ~w_legal;
    end

    assign o_bundle_c = w_bundle;

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: decodes MIPS ALU instructions and presents the bundle
// through a registered valid/ready handshake backed by a main + skid entry.
module alu_issue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   inst,
    input  logic [XLEN-1:0]   rs_value,
    input  logic [XLEN-1:0]   rt_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic [XLEN-1:0]   alu_src1,
    output logic [XLEN-1:0]   alu_src2,
    output logic [REG_W-1:0]  dest,
    output logic              wen,
    output logic              illegal
);

    issue_t w_dec;
    issue_t r_main;
    issue_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;
    logic   r_in_ready;

    issue_t w_main_nxt;
    issue_t w_skid_nxt;
    logic   w_main_valid_nxt;
    logic   w_skid_valid_nxt;
    logic   w_accept;
    logic   w_pop;

    alu_dec u_dec (
        .i_inst     (inst),
        .i_rs_value (rs_value),
        .i_rt_value (rt_value),
        .o_bundle_c (w_dec)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_main_valid & out_ready;

    // Skid only fills while main is held, so main refills from skid first to keep order.
    always_comb begin
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_pop || !r_main_valid) begin
            if (r_skid_valid) begin
                w_main_nxt       = r_skid;
                w_main_valid_nxt = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_main_valid_nxt = w_accept;
                if (w_accept) begin
                    w_main_nxt = w_dec;
                end
            end
        end else if (w_accept) begin
            w_skid_nxt       = w_dec;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign alu_control = r_main.alu_control;
    assign alu_src1    = r_main.src1;
    assign alu_src2    = r_main.src2;
    assign dest        = r_main.dest;
    assign wen         = r_main.wen;
    assign illegal     = r_main.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, skid backpressure ordering,
// flush and asynchronous reset.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = '0;
    logic [31:0] rs_value = '0;
    logic [31:0] rt_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst        (inst),
        .rs_value    (rs_value),
        .rt_value    (rt_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .dest        (dest),
        .wen         (wen),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bundle(input string tag, input logic [11:0] c, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [4:0] d, input logic w,
                              input logic il);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ctrl"},  32'(alu_control), 32'(c));
        chk({tag, ".src1"},  alu_src1, s1);
        chk({tag, ".src2"},  alu_src2, s2);
        chk({tag, ".dest"},  32'(dest), 32'(d));
        chk({tag, ".wen"},   32'(wen), 32'(w));
        chk({tag, ".ill"},   32'(illegal), 32'(il));
    endtask

    initial begin
        #1 resetn = 1'b0;
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.ctrl",  32'(alu_control), 32'd0);
        chk("rst.src1",  alu_src1, 32'd0);
        chk("rst.src2",  alu_src2, 32'd0);
        chk("rst.dest",  32'(dest), 32'd0);
        chk("rst.wen",   32'(wen), 32'd0);
        chk("rst.ill",   32'(illegal), 32'd0);
        step();
        step();
        resetn = 1'b1;
        step();

        // ADDIU $9,$8,-1
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 32'h2509FFFF; rs_value = 32'd5; rt_value = 32'd0;
        step();
        chk_bundle("addiu", 12'h800, 32'd5, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0);

        // SLL $10,$9,4
        inst = 32'h00095100; rs_value = 32'h0; rt_value = 32'd3;
        step();
        chk_bundle("sll", 12'h008, 32'd3, 32'd4, 5'd10, 1'b1, 1'b0);

        // LUI $1,0x1234
        inst = 32'h3C011234; rs_value = 32'd7; rt_value = 32'd0;
        step();
        chk_bundle("lui", 12'h001, 32'd7, 32'h00001234, 5'd1, 1'b1, 1'b0);

        // ANDI $9,$8,0x8000: zero-extended immediate
        inst = 32'h31098000; rs_value = 32'hFFFF0000; rt_value = 32'd0;
        step();
        chk_bundle("andi", 12'h080, 32'hFFFF0000, 32'h00008000, 5'd9, 1'b1, 1'b0);

        // SRAV $5,$4,$3: amount from rs_value[4:0]
        inst = 32'h00642807; rs_value = 32'h00000123; rt_value = 32'h80000000;
        step();
        chk_bundle("srav", 12'h002, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0);

        // Illegal opcode
        inst = 32'hFC000000; rs_value = 32'd0; rt_value = 32'd0;
        step();
        chk("ill.valid", 32'(out_valid), 32'd1);
        chk("ill.ill",   32'(illegal), 32'd1);
        chk("ill.ctrl",  32'(alu_control), 32'd0);
        chk("ill.wen",   32'(wen), 32'd0);

        // ADDU $0,$1,$2: legal but no write
        inst = 32'h00220021; rs_value = 32'd1; rt_value = 32'd2;
        step();
        chk_bundle("addu0", 12'h800, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);

        in_valid = 1'b0;
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);
        chk("drain.ready", 32'(in_ready), 32'd1);

        // Backpressure: three ORI entries A,B,C against a stalled consumer
        out_ready = 1'b0; rs_value = 32'd0; rt_value = 32'd0;
        in_valid = 1'b1; inst = 32'h34020001;
        step();
        chk("bp1.valid", 32'(out_valid), 32'd1);
        chk("bp1.dest",  32'(dest), 32'd2);
        chk("bp1.ready", 32'(in_ready), 32'd1);
        inst = 32'h34030002;
        step();
        chk("bp2.ready", 32'(in_ready), 32'd0);
        chk("bp2.dest",  32'(dest), 32'd2);
        inst = 32'h34040003;
        step();
        chk("bp3.ready", 32'(in_ready), 32'd0);
        chk("bp3.valid", 32'(out_valid), 32'd1);
        chk("bp3.dest",  32'(dest), 32'd2);
        chk("bp3.src2",  alu_src2, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp4.valid", 32'(out_valid), 32'd1);
        chk("bp4.dest",  32'(dest), 32'd3);
        chk("bp4.src2",  alu_src2, 32'd2);
        chk("bp4.ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp5.valid", 32'(out_valid), 32'd1);
        chk("bp5.dest",  32'(dest), 32'd4);
        chk("bp5.src2",  alu_src2, 32'd3);
        step();
        chk("bp6.valid", 32'(out_valid), 32'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h34020001;
        step();
        inst = 32'h34030002;
        step();
        chk("fl.full", 32'(in_ready), 32'd0);
        inst = 32'h34040003; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.ready", 32'(in_ready), 32'd1);
        step();
        chk("fl.stay", 32'(out_valid), 32'd0);

        // Flush discards an entry accepted in the same cycle
        in_valid = 1'b1; inst = 32'h34020001; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flacc.valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stall
        in_valid = 1'b1; inst = 32'h34020001;
        step();
        inst = 32'h34030002;
        step();
        in_valid = 1'b0;
        chk("ar.pre",  32'(out_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("ar.valid", 32'(out_valid), 32'd0);
        chk("ar.ready", 32'(in_ready), 32'd1);
        chk("ar.ctrl",  32'(alu_control), 32'd0);
        resetn = 1'b1;
        step();
        out_ready = 1'b1;
        step();
        chk("ar.after", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
